// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetches 128-bit lines from the i-cache and
// hands them to decode one 32-bit word per cycle, with redirect and lost-fetch recovery.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  Pc_out,
  output logic         Rd_en,
  input  logic [127:0] Cache_dout,
  input  logic         Cache_dout_valid,
  input  logic         Redirect,
  input  logic [31:0]  Redirect_pc,
  output logic [31:0]  Inst,
  output logic [31:0]  Inst_pc,
  output logic         Inst_valid,
  input  logic         Inst_ready,
  output logic         Timeout_err
);

  // state | meaning
  // IDLE  | just out of reset, start fetching next cycle
  // REQ   | single-cycle read request for the line holding fetch_pc
  // WAIT  | request outstanding, waiting for the line
  // SERVE | line buffered, presenting words to decode
  // DRAIN | redirected while a request was outstanding; swallow its response
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SERVE, DRAIN} state_t;

  localparam int             CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WAIT);

  state_t         state, state_nxt;
  logic [31:0]    fetch_pc, fetch_pc_nxt;
  logic [127:0]   line_buf;
  logic           buf_valid, buf_valid_nxt;
  logic           capture;
  logic [CW-1:0]  wait_cnt, wait_cnt_nxt, wait_cnt_inc;
  logic           timeout_nxt;
  logic [31:0]    redirect_tgt, pc_inc, buf_word;
  logic           unused_redirect_lsb;

  assign redirect_tgt        = {Redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^Redirect_pc[1:0];
  assign pc_inc              = fetch_pc + 32'd4;
  assign wait_cnt_inc        = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CW'(1);

  always_comb begin
    case (fetch_pc[3:2])
      2'd0:    buf_word = line_buf[127:96];
      2'd1:    buf_word = line_buf[95:64];
      2'd2:    buf_word = line_buf[63:32];
      default: buf_word = line_buf[31:0];
    endcase
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    buf_valid_nxt = buf_valid;
    capture       = 1'b0;
    wait_cnt_nxt  = wait_cnt;
    timeout_nxt   = Timeout_err;
    Rd_en         = 1'b0;
    Inst_valid    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (Redirect) begin
          fetch_pc_nxt  = redirect_tgt;
          buf_valid_nxt = 1'b0;
        end
      end
      REQ: begin
        Rd_en        = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = WAIT;
        if (Redirect) begin
          fetch_pc_nxt  = redirect_tgt;
          buf_valid_nxt = 1'b0;
          state_nxt     = REQ;
        end
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt_inc;
        if (Redirect) begin
          fetch_pc_nxt  = redirect_tgt;
          buf_valid_nxt = 1'b0;
          state_nxt     = Cache_dout_valid ? REQ : DRAIN;
        end else if (Cache_dout_valid) begin
          capture       = 1'b1;
          buf_valid_nxt = 1'b1;
          state_nxt     = SERVE;
        end else if (wait_cnt_inc == CNT_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = REQ;
        end
      end
      DRAIN: begin
        wait_cnt_nxt = wait_cnt_inc;
        if (Redirect) fetch_pc_nxt = redirect_tgt;
        if (Cache_dout_valid) begin
          state_nxt = REQ;
        end else if (wait_cnt_inc == CNT_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = REQ;
        end
      end
      SERVE: begin
        Inst_valid = buf_valid;
        if (Inst_ready) begin
          fetch_pc_nxt = pc_inc;
          if (pc_inc[3:2] == 2'd0) begin
            buf_valid_nxt = 1'b0;
            state_nxt     = REQ;
          end
        end
        // A redirect on the transfer cycle still lets decode keep the word.
        if (Redirect) begin
          fetch_pc_nxt  = redirect_tgt;
          buf_valid_nxt = 1'b0;
          state_nxt     = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Pc_out  = {fetch_pc[31:4], 4'b0000};
  assign Inst    = Inst_valid ? buf_word : 32'h0;
  assign Inst_pc = Inst_valid ? fetch_pc : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      line_buf    <= '0;
      buf_valid   <= 1'b0;
      wait_cnt    <= '0;
      Timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      buf_valid   <= buf_valid_nxt;
      wait_cnt    <= wait_cnt_nxt;
      Timeout_err <= timeout_nxt;
      if (capture) line_buf <= Cache_dout;
    end
  end

endmodule
